// File: rtl/bsearch_engine.sv
// rtl/bsearch_engine.sv - lower/upper-bound binary search over a sorted table in a synchronous-read RAM
// Reports first/last occurrence on a hit and the insertion point on a miss.
module bsearch_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic [DATA_W-1:0] i_key,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_found,
  output logic [ADDR_W:0]   o_index,
  output logic [ADDR_W:0]   o_probes
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_key;
  logic              r_mode;
  logic [PW-1:0]     r_lo;
  logic [PW-1:0]     r_hi;
  logic [PW-1:0]     r_mid;
  logic              r_eq;
  logic [PW-1:0]     r_count;
  logic [1:0]        r_wait;

  logic [PW:0]       w_sum;
  logic [PW-1:0]     w_mid;
  logic              w_go_right;
  logic              w_hit;
  logic [PW-1:0]     w_lo_next;
  logic [PW-1:0]     w_hi_next;
  logic              w_eq_next;
  logic [PW-1:0]     w_count_next;

  // lo+hi can reach 2*DEPTH, so the sum carries one extra bit before halving
  assign w_sum        = {1'b0, r_lo} + {1'b0, r_hi};
  assign w_mid        = PW'(w_sum >> 1);
  assign w_go_right   = r_mode ? (i_mem_rdata <= r_key) : (i_mem_rdata < r_key);
  assign w_hit        = (i_mem_rdata == r_key);
  assign w_lo_next    = w_go_right ? (r_mid + PW'(1)) : r_lo;
  assign w_hi_next    = w_go_right ? r_hi : r_mid;
  assign w_eq_next    = r_eq | w_hit;
  assign w_count_next = r_count + PW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      o_mem_addr <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_found    <= 1'b0;
      o_index    <= '0;
      o_probes   <= '0;
      r_key      <= '0;
      r_mode     <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_mid      <= '0;
      r_eq       <= 1'b0;
      r_count    <= '0;
      r_wait     <= '0;
    end else if (i_abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_key    <= i_key;
            r_mode   <= i_mode;
            r_lo     <= '0;
            r_hi     <= DEPTH;
            r_eq     <= 1'b0;
            r_count  <= '0;
            o_found  <= 1'b0;
            o_index  <= '0;
            o_probes <= '0;
            o_busy   <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_mid      <= w_mid;
          o_mem_addr <= w_mid[ADDR_W-1:0];
          r_wait     <= 2'(READ_LAT - 1);
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait == 2'd0) begin
            r_state <= S_COMPARE;
          end else begin
            r_wait <= r_wait - 2'd1;
          end
        end
        S_COMPARE: begin
          r_lo    <= w_lo_next;
          r_hi    <= w_hi_next;
          r_eq    <= w_eq_next;
          r_count <= w_count_next;
          // Results are published on the final compare edge so done lands P*(READ_LAT+2) edges after start
          if (w_lo_next == w_hi_next) begin
            o_done   <= 1'b1;
            o_busy   <= 1'b0;
            o_found  <= w_eq_next;
            o_probes <= w_count_next;
            o_index  <= (r_mode && w_eq_next) ? (w_lo_next - PW'(1)) : w_lo_next;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_SETUP;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsearch_engine.sv
// tb/tb_bsearch_engine.sv - randomized bench for bsearch_engine against a counting reference model
module tb_bsearch_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, abort_a, mode_a, busy_a, done_a, found_a;
  logic [7:0]  key_a, rdata_a;
  logic [4:0]  addr_a;
  logic [5:0]  index_a, probes_a;
  logic        start_b, abort_b, mode_b, busy_b, done_b, found_b;
  logic [11:0] key_b, rdata_b;
  logic [5:0]  addr_b;
  logic [6:0]  index_b, probes_b;

  logic [7:0]  mem_a [32];
  logic [11:0] mem_b [64];
  logic [11:0] pipe_b [3];

  int vectors = 0;
  int miscompares = 0;

  bsearch_engine u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start_a), .i_abort(abort_a), .i_mode(mode_a),
    .i_key(key_a), .o_mem_addr(addr_a), .i_mem_rdata(rdata_a), .o_busy(busy_a),
    .o_done(done_a), .o_found(found_a), .o_index(index_a), .o_probes(probes_a)
  );

  bsearch_engine #(.DATA_W(12), .ADDR_W(6), .READ_LAT(3)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_abort(abort_b), .i_mode(mode_b),
    .i_key(key_b), .o_mem_addr(addr_b), .i_mem_rdata(rdata_b), .o_busy(busy_b),
    .o_done(done_b), .o_found(found_b), .o_index(index_b), .o_probes(probes_b)
  );

  always @(posedge clk) rdata_a <= mem_a[addr_a];
  always @(posedge clk) begin
    pipe_b[0] <= mem_b[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2];

  // Expected results from counting entries below / not above the key; probe count from halving [0,DEPTH] toward that bound
  task automatic model(input bit use_b, input int key, input bit mode,
                       output logic e_found, output int e_index, output int e_probes);
    int depth, v, n_lt, n_le, tgt, lo, hi, mid;
    depth = use_b ? 64 : 32;
    n_lt = 0;
    n_le = 0;
    for (int i = 0; i < depth; i++) begin
      if (use_b) v = int'(mem_b[i]); else v = int'(mem_a[i]);
      if (v < key) n_lt++;
      if (v <= key) n_le++;
    end
    e_found = (n_le > n_lt);
    tgt = mode ? n_le : n_lt;
    e_index = (mode && e_found) ? n_le - 1 : tgt;
    lo = 0;
    hi = depth;
    e_probes = 0;
    while (lo < hi) begin
      mid = (lo + hi) / 2;
      e_probes++;
      if (mid < tgt) lo = mid + 1; else hi = mid;
    end
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_a || done_a) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic search_a(input logic [7:0] k, input logic m, output int lat);
    wait_idle_a();
    key_a = k;
    mode_a = m;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic search_b(input logic [11:0] k, input logic m, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_b || done_b) && n < 300) begin
      @(negedge clk);
      n++;
    end
    key_b = k;
    mode_b = m;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    lat = 0;
    while (!done_b && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0; key_a = '0;
    start_b = 1'b0; abort_b = 1'b0; mode_b = 1'b0; key_b = '0;
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(4 * i);
    for (int i = 0; i < 64; i++) mem_b[i] = 12'(3 * i);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    vectors++;
    if ({busy_a, done_a, found_a} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags_a: busy/done/found=%b want 000", {busy_a, done_a, found_a});
    end
    vectors++;
    if ({index_a, probes_a, addr_a} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_values_a: index=%0d probes=%0d addr=%0d want 0/0/0", index_a, probes_a, addr_a);
    end
    vectors++;
    if ({busy_b, done_b, found_b, index_b, probes_b, addr_b} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_b: busy=%b done=%b found=%b index=%0d probes=%0d addr=%0d want all 0",
               busy_b, done_b, found_b, index_b, probes_b, addr_b);
    end
  endtask

  task automatic test_exact();
    logic [7:0] keys [8];
    logic [7:0] k;
    logic m, ef;
    int ei, ep, lat;
    keys = '{8'd100, 8'd101, 8'd0, 8'd200, 8'd124, 8'd3, 8'd127, 8'd128};
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(4 * i);
    for (int n = 0; n < 32; n++) begin
      k = (n < 8) ? keys[n] : 8'($urandom_range(0, 140));
      m = (n < 5) ? 1'b0 : 1'($urandom_range(0, 1));
      model(1'b0, int'(k), m, ef, ei, ep);
      search_a(k, m, lat);
      vectors++;
      if (found_a !== ef || int'(index_a) !== ei || int'(probes_a) !== ep) begin
        miscompares++;
        $display("FAIL exact key=%0d mode=%0d: found=%b index=%0d probes=%0d want %b/%0d/%0d",
                 k, m, found_a, index_a, probes_a, ef, ei, ep);
      end
      vectors++;
      if (lat !== ep * 3) begin
        miscompares++;
        $display("FAIL exact_latency key=%0d: done after %0d cycles want %0d", k, lat, ep * 3);
      end
      vectors++;
      if (int'(probes_a) > 6) begin
        miscompares++;
        $display("FAIL probe_bound key=%0d: probes=%0d want <= 6", k, probes_a);
      end
    end
  endtask

  task automatic test_duplicates();
    logic [7:0] keys [8];
    logic       modes [8];
    logic [7:0] k;
    logic m, ef;
    int ei, ep, lat, acc;
    keys  = '{8'd7, 8'd7, 8'd4, 8'd4, 8'd5, 8'd44, 8'd45, 8'd0};
    modes = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 32; i++) begin
      if (i < 10) mem_a[i] = 8'(i / 2);
      else if (i < 14) mem_a[i] = 8'd7;
      else mem_a[i] = 8'(8 + 2 * (i - 14));
    end
    for (int t = 0; t < 5; t++) begin
      if (t > 0) begin
        acc = 0;
        for (int i = 0; i < 32; i++) begin
          acc += int'($urandom_range(0, 2));
          mem_a[i] = 8'(acc);
        end
      end
      for (int n = 0; n < 8; n++) begin
        k = (t == 0) ? keys[n] : 8'($urandom_range(0, 70));
        m = (t == 0) ? modes[n] : 1'($urandom_range(0, 1));
        model(1'b0, int'(k), m, ef, ei, ep);
        search_a(k, m, lat);
        vectors++;
        if (found_a !== ef || int'(index_a) !== ei || int'(probes_a) !== ep || lat !== ep * 3) begin
          miscompares++;
          $display("FAIL dup key=%0d mode=%0d: found=%b index=%0d probes=%0d lat=%0d want %b/%0d/%0d/%0d",
                   k, m, found_a, index_a, probes_a, lat, ef, ei, ep, ep * 3);
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [11:0] keys [4];
    logic [11:0] k;
    logic m, ef;
    int ei, ep, lat;
    keys = '{12'd99, 12'd0, 12'd189, 12'd300};
    for (int i = 0; i < 64; i++) mem_b[i] = 12'(3 * i);
    for (int n = 0; n < 14; n++) begin
      k = (n < 4) ? keys[n] : 12'($urandom_range(0, 200));
      m = (n < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      model(1'b1, int'(k), m, ef, ei, ep);
      search_b(k, m, lat);
      vectors++;
      if (found_b !== ef || int'(index_b) !== ei || int'(probes_b) !== ep) begin
        miscompares++;
        $display("FAIL wide key=%0d mode=%0d: found=%b index=%0d probes=%0d want %b/%0d/%0d",
                 k, m, found_b, index_b, probes_b, ef, ei, ep);
      end
      vectors++;
      if (lat !== ep * 5) begin
        miscompares++;
        $display("FAIL wide_latency key=%0d: done after %0d cycles want %0d", k, lat, ep * 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ef, saw;
    int ei, ep, lat;
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(4 * i);
    wait_idle_a();
    key_a = 8'd100; mode_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b done=%b addr=%0d want 0/0/0", busy_a, done_a, addr_a);
    end
    saw = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done_a || busy_a) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: activity=%b after reset want 0", saw);
    end
    model(1'b0, 101, 1'b0, ef, ei, ep);
    search_a(8'd101, 1'b0, lat);
    vectors++;
    if (found_a !== ef || int'(index_a) !== ei || int'(probes_a) !== ep || lat !== ep * 3) begin
      miscompares++;
      $display("FAIL reset_mid_restart: found=%b index=%0d probes=%0d lat=%0d want %b/%0d/%0d/%0d",
               found_a, index_a, probes_a, lat, ef, ei, ep, ep * 3);
    end
  endtask

  task automatic test_abort();
    logic ef, saw;
    int ei, ep, lat;
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(4 * i);
    search_a(8'd100, 1'b0, lat);
    vectors++;
    if (found_a !== 1'b1 || index_a !== 6'd25) begin
      miscompares++;
      $display("FAIL abort_pre: found=%b index=%0d want 1/25", found_a, index_a);
    end
    wait_idle_a();
    key_a = 8'd124; mode_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    vectors++;
    if (busy_a !== 1'b0 || found_a !== 1'b0 || index_a !== 6'd0 || probes_a !== 6'd0) begin
      miscompares++;
      $display("FAIL abort: busy=%b found=%b index=%0d probes=%0d want 0/0/0/0",
               busy_a, found_a, index_a, probes_a);
    end
    saw = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done_a) saw = 1'b1;
    end
    vectors++;
    if (saw !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: done seen=%b want 0", saw);
    end
    // Start pulses and key changes while busy must not disturb the running search
    wait_idle_a();
    key_a = 8'd100; mode_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 200) begin
      if (lat < 10) begin
        start_a = lat[0];
        key_a = 8'($urandom_range(0, 255));
        mode_a = 1'($urandom_range(0, 1));
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start_a = 1'b0;
    model(1'b0, 100, 1'b0, ef, ei, ep);
    vectors++;
    if (found_a !== ef || int'(index_a) !== ei || int'(probes_a) !== ep || lat !== ep * 3) begin
      miscompares++;
      $display("FAIL start_while_busy: found=%b index=%0d probes=%0d lat=%0d want %b/%0d/%0d/%0d",
               found_a, index_a, probes_a, lat, ef, ei, ep, ep * 3);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] k2;
    logic ef;
    int ei, ep, lat;
    for (int i = 0; i < 32; i++) mem_a[i] = 8'(4 * i);
    k2 = 8'($urandom_range(0, 130));
    wait_idle_a();
    key_a = 8'd100; mode_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done_a && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    model(1'b0, 100, 1'b0, ef, ei, ep);
    vectors++;
    if (found_a !== ef || int'(index_a) !== ei || lat !== ep * 3) begin
      miscompares++;
      $display("FAIL b2b_first: found=%b index=%0d lat=%0d want %b/%0d/%0d", found_a, index_a, lat, ef, ei, ep * 3);
    end
    key_a = k2;
    mode_a = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_pulse: done=%b busy=%b one cycle after done want 0/0", done_a, busy_a);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy_a !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: busy=%b on first idle edge want 1", busy_a);
    end
    lat = 0;
    while (!done_a && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    start_a = 1'b0;
    model(1'b0, int'(k2), 1'b1, ef, ei, ep);
    vectors++;
    if (found_a !== ef || int'(index_a) !== ei || int'(probes_a) !== ep || lat !== ep * 3) begin
      miscompares++;
      $display("FAIL b2b_second key=%0d: found=%b index=%0d probes=%0d lat=%0d want %b/%0d/%0d/%0d",
               k2, found_a, index_a, probes_a, lat, ef, ei, ep, ep * 3);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_stop: busy=%b after start dropped want 0", busy_a);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_duplicates();
    test_wide();
    test_reset_mid();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1);
  end

endmodule
